// File: rtl/ysyx_pkg.sv
// Shared types for the data-memory responder: FSM states, counter width and an
// index-width helper used by both the top level and the word array.
package ysyx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int CNT_W = 4;

  // Width of a word index; a single-word array still gets a 1-bit index.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ysyx_dmem_array.sv
// Single-port 32-bit word store with byte-enable write and registered read.
// Read data updates only on an enabled read, so it stays put while a response waits.
module ysyx_dmem_array
  import ysyx_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic                          we,
  input  logic [3:0]                    wmask,
  input  logic [idx_w(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_dmem_resp.sv
// Data-memory responder: one load/store in flight, response LATENCY edges after accept.
// resp_ready low parks the FSM in RESP with outputs frozen; req_ready is high only in IDLE.
module ysyx_dmem_resp
  import ysyx_pkg::*;
#(
  parameter int          LATENCY     = 1,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int               IDX_W    = idx_w(DEPTH_WORDS);
  localparam logic [32:0]      ADDR_END = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic             rd_ok_q, rd_ok_d;

  logic             accept;
  logic             addr_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      arr_rdata;

  assign accept   = req_ready_q && req_valid;
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr < ADDR_BASE) ||
                    ({1'b0, req_addr} >= ADDR_END);
  assign idx      = IDX_W'((req_addr - ADDR_BASE) >> 2);

  // The array is touched only on the accept edge, and never for a bad address.
  ysyx_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (accept && !addr_err),
    .we    (req_wen),
    .wmask (req_wmask),
    .idx   (idx),
    .wdata (req_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    rd_ok_d      = rd_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          resp_err_d = addr_err;
          rd_ok_d    = !addr_err && !req_wen;
          cnt_d      = CNT_LOAD;
          state_d    = (CNT_LOAD == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = ST_RESP;
      end
      ST_RESP: begin
        // resp_valid trails entry into RESP by one edge, giving accept-to-valid = LATENCY.
        if (resp_valid_q && resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          rd_ok_d      = 1'b0;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rd_ok_q      <= rd_ok_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rd_ok_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_ysyx_dmem_resp.sv
// Bench for ysyx_dmem_resp: three instances (LATENCY 1, 4, 8) against a transaction-level
// model of memory contents and response timing, plus directed literal expectations.
module tb_ysyx_dmem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_s  [3];
  logic        req_wen_s    [3];
  logic [31:0] req_addr_s   [3];
  logic [31:0] req_wdata_s  [3];
  logic [3:0]  req_wmask_s  [3];
  logic        resp_ready_s [3];
  logic        req_ready_w  [3];
  logic        resp_valid_w [3];
  logic [31:0] resp_rdata_w [3];
  logic        resp_err_w   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_dmem_resp #(.LATENCY(lat_of(g)), .DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid_s[g]),
      .req_ready  (req_ready_w[g]),
      .req_wen    (req_wen_s[g]),
      .req_addr   (req_addr_s[g]),
      .req_wdata  (req_wdata_s[g]),
      .req_wmask  (req_wmask_s[g]),
      .resp_valid (resp_valid_w[g]),
      .resp_ready (resp_ready_s[g]),
      .resp_rdata (resp_rdata_w[g]),
      .resp_err   (resp_err_w[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, g, act, exp);
    end
  endtask

  // Model: memory image per instance plus the one outstanding transaction.
  logic [31:0] m_mem   [3][DEPTH];
  bit          m_wr    [3][DEPTH];
  bit          m_out   [3];
  int          m_acc   [3];
  logic [31:0] m_rdata [3];
  bit          m_err   [3];
  bit          m_known [3];
  int          acc_cnt [3];
  int          hs_cnt  [3];
  int          cyc = 0;

  initial begin
    for (int g = 0; g < 3; g++) begin
      m_out[g] = 0; m_acc[g] = 0; m_rdata[g] = '0; m_err[g] = 0; m_known[g] = 1;
      acc_cnt[g] = 0; hs_cnt[g] = 0;
      for (int i = 0; i < DEPTH; i++) begin m_wr[g][i] = 0; m_mem[g][i] = '0; end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        m_out[g] = 0;
      end else begin
        bit was_idle;
        was_idle = !m_out[g];
        if (m_out[g] && (cyc > m_acc[g] + lat_of(g)) && resp_ready_s[g]) begin
          m_out[g] = 0;
          hs_cnt[g]++;
        end
        if (was_idle && req_valid_s[g]) begin
          longint a;
          int     ix;
          a  = longint'(req_addr_s[g]);
          ix = int'((a - longint'(BASE)) >>> 2);
          m_out[g]   = 1;
          m_acc[g]   = cyc;
          acc_cnt[g]++;
          m_err[g]   = (req_addr_s[g][1:0] != 2'b00) || (a < longint'(BASE)) ||
                       (a >= longint'(BASE) + 4 * DEPTH);
          m_rdata[g] = '0;
          m_known[g] = 1;
          if (!m_err[g]) begin
            if (req_wen_s[g]) begin
              for (int b = 0; b < 4; b++)
                if (req_wmask_s[g][b]) m_mem[g][ix][8*b +: 8] = req_wdata_s[g][8*b +: 8];
              if (req_wmask_s[g] == 4'hF) m_wr[g][ix] = 1;
            end else begin
              m_rdata[g] = m_mem[g][ix];
              m_known[g] = m_wr[g][ix];
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        chk("rst_req_ready", g, 32'(req_ready_w[g]), 32'd1);
        chk("rst_resp_valid", g, 32'(resp_valid_w[g]), 32'd0);
        chk("rst_resp_rdata", g, resp_rdata_w[g], 32'd0);
        chk("rst_resp_err", g, 32'(resp_err_w[g]), 32'd0);
      end else begin
        bit ev;
        ev = m_out[g] && (cyc >= m_acc[g] + lat_of(g));
        chk("resp_valid", g, 32'(resp_valid_w[g]), 32'(ev));
        chk("req_ready", g, 32'(req_ready_w[g]), 32'(!m_out[g]));
        if (ev) begin
          chk("resp_err", g, 32'(resp_err_w[g]), 32'(m_err[g]));
          if (m_known[g]) chk("resp_rdata", g, resp_rdata_w[g], m_rdata[g]);
        end else if (!m_out[g]) begin
          chk("idle_rdata", g, resp_rdata_w[g], 32'd0);
          chk("idle_err", g, 32'(resp_err_w[g]), 32'd0);
        end
      end
    end
  end

  // One directed transaction; hold = cycles of resp_ready low once resp_valid is seen.
  task automatic txn(input int g, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    int a;
    req_valid_s[g] = 1'b1; req_wen_s[g] = wen; req_addr_s[g] = addr;
    req_wdata_s[g] = wdata; req_wmask_s[g] = mask; resp_ready_s[g] = 1'b0;
    n = 0;
    while (!req_ready_w[g] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    a = cyc;
    req_valid_s[g] = 1'b0; req_wen_s[g] = ~wen; req_addr_s[g] = 32'hFFFF_FFF3;
    req_wdata_s[g] = ~wdata; req_wmask_s[g] = ~mask;
    n = 0;
    while (!resp_valid_w[g] && n < 40) begin @(posedge clk); #1; n++; end
    lat = cyc - a;
    rd  = resp_rdata_w[g];
    er  = resp_err_w[g];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rdata", g, resp_rdata_w[g], rd);
      chk("hold_valid", g, 32'(resp_valid_w[g]), 32'd1);
      chk("hold_req_ready", g, 32'(req_ready_w[g]), 32'd0);
    end
    resp_ready_s[g] = 1'b1;
    @(posedge clk); #1;
    resp_ready_s[g] = 1'b0;
    chk("post_hs_req_ready", g, 32'(req_ready_w[g]), 32'd1);
    chk("post_hs_valid", g, 32'(resp_valid_w[g]), 32'd0);
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          iter;
    bit          done;
    for (int g = 0; g < 3; g++) begin
      req_valid_s[g] = 0; req_wen_s[g] = 0; req_addr_s[g] = '0;
      req_wdata_s[g] = '0; req_wmask_s[g] = '0; resp_ready_s[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1 write then read
    txn(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    chk("wr_latency", 0, lat, 1);
    chk("wr_err", 0, 32'(er), 0);
    chk("wr_rdata", 0, rd, 32'h0);
    txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd_deadbeef", 0, rd, 32'hDEAD_BEEF);

    // Byte mask merge, then an all-zero mask that must change nothing
    txn(0, 1, 32'h8000_0014, 32'h1122_3344, 4'hF, 0, rd, er, lat);
    txn(0, 1, 32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 0, rd, er, lat);
    txn(0, 0, 32'h8000_0014, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd_mask0101", 0, rd, 32'h11BB_33DD);
    txn(0, 1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
    txn(0, 0, 32'h8000_0014, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rd_mask0000", 0, rd, 32'h11BB_33DD);

    // Errors and range boundaries
    txn(0, 0, 32'h8000_0002, 32'h0, 4'h0, 0, rd, er, lat);
    chk("misalign_err", 0, 32'(er), 1);
    chk("misalign_rdata", 0, rd, 32'h0);
    txn(0, 1, 32'h8000_0FFC, 32'h5A5A_5A5A, 4'hF, 0, rd, er, lat);
    chk("last_word_err", 0, 32'(er), 0);
    txn(0, 1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    chk("below_base_err", 0, 32'(er), 1);
    txn(0, 0, 32'h8000_0FFC, 32'h0, 4'h0, 0, rd, er, lat);
    chk("below_base_nowrite", 0, rd, 32'h5A5A_5A5A);
    txn(0, 1, 32'h8000_0000, 32'h0BAD_C0DE, 4'hF, 0, rd, er, lat);
    txn(0, 1, 32'h8000_1000, 32'h8765_4321, 4'hF, 0, rd, er, lat);
    chk("past_end_err", 0, 32'(er), 1);
    txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lat);
    chk("past_end_nowrite", 0, rd, 32'h0BAD_C0DE);

    // LATENCY=4 with three cycles of backpressure
    txn(1, 1, 32'h8000_0020, 32'h600D_F00D, 4'hF, 0, rd, er, lat);
    txn(1, 0, 32'h8000_0020, 32'h0, 4'h0, 3, rd, er, lat);
    chk("l4_latency", 1, lat, 4);
    chk("l4_rdata", 1, rd, 32'h600D_F00D);

    // LATENCY=8: reset while the write waits with counter at 3
    req_valid_s[2] = 1; req_wen_s[2] = 1; req_addr_s[2] = 32'h8000_0040;
    req_wdata_s[2] = 32'hCAFE_F00D; req_wmask_s[2] = 4'hF;
    @(posedge clk); #1;
    req_valid_s[2] = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", 2, 32'(req_ready_w[2]), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("rst_no_resp", 2, 32'(resp_valid_w[2]), 32'd0);
      chk("rst_req_ready_after", 2, 32'(req_ready_w[2]), 32'd1);
    end
    txn(2, 0, 32'h8000_0040, 32'h0, 4'h0, 0, rd, er, lat);
    chk("l8_latency", 2, lat, 8);
    chk("rst_write_kept", 2, rd, 32'hCAFE_F00D);

    // Random traffic with requests held during WAIT/RESP
    for (int g = 0; g < 3; g++) begin acc_cnt[g] = 0; hs_cnt[g] = 0; end
    iter = 0;
    done = 0;
    while (!done && iter < 40000) begin
      for (int g = 0; g < 3; g++) begin
        int r;
        r = $urandom_range(0, 19);
        req_valid_s[g] = ($urandom_range(0, 9) != 0);
        req_wen_s[g]   = 1'($urandom_range(0, 1));
        if (r == 0)      req_addr_s[g] = BASE + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
        else if (r == 1) req_addr_s[g] = BASE - (32'($urandom_range(1, 4)) << 2);
        else if (r == 2) req_addr_s[g] = BASE + 32'h1000 + (32'($urandom_range(0, 4)) << 2);
        else             req_addr_s[g] = BASE + (32'($urandom_range(0, 63)) << 2);
        req_wdata_s[g]  = $urandom;
        req_wmask_s[g]  = 4'($urandom_range(0, 15));
        resp_ready_s[g] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      iter++;
      done = (acc_cnt[0] >= 1000) && (acc_cnt[1] >= 1000) && (acc_cnt[2] >= 1000);
    end
    for (int g = 0; g < 3; g++) begin req_valid_s[g] = 0; resp_ready_s[g] = 1; end
    repeat (30) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("random_count_reached", g, 32'(acc_cnt[g] >= 1000), 32'd1);
      chk("one_resp_per_req", g, 32'(hs_cnt[g]), 32'(acc_cnt[g]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
